// File: rtl/dht11_sensor_emulator_pkg.sv
// Shared DHT11 definitions: FSM state encoding, default timing table and frame helpers.
// Used by the sensor emulator and intended for the host-side receiver as well,
// so both ends of the link agree on one timing table (1 cycle = 1 us).
package dht11_sensor_emulator_pkg;

    localparam int T_START_MIN_DEF = 18000;
    localparam int T_WAIT_DEF      = 30;
    localparam int T_RESP_LOW_DEF  = 80;
    localparam int T_RESP_HIGH_DEF = 80;
    localparam int T_BIT_LOW_DEF   = 50;
    localparam int T_ZERO_HIGH_DEF = 26;
    localparam int T_ONE_HIGH_DEF  = 70;

    localparam int FRAME_W   = 40;
    localparam int BIT_IDX_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOST_LOW,
        ST_WAIT,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_END_LOW
    } dht_state_t;

    // 8-bit truncated sum of the four data bytes.
    function automatic logic [7:0] frame_checksum(input logic [31:0] v);
        return v[31:24] + v[23:16] + v[15:8] + v[7:0];
    endfunction

    // Wire order, MSB first: hum_int, hum_dec, temp_int, temp_dec, checksum.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [31:0] v);
        return {v, frame_checksum(v)};
    endfunction

endpackage

// File: rtl/dht11_line_sync.sv
// 2-FF synchroniser for the raw single-wire level, plus one-cycle rise/fall pulses.
// Ports: clk, rst (async active-low), din (async line level) -> rise, fall.
// Latency: edge pulse appears 2 cycles after the line change is first sampled; no backpressure.
module dht11_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Reset to the idle (pulled-up) level so release from reset never looks like a host falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/dht11_sensor_emulator.sv
// DHT11 sensor-side emulator: detects host start pulse, sends response preamble and 40-bit frame.
// Ports: clk/rst, load + four value bytes (shadowed), dht_in line level -> dht_oe (open-drain pull),
// busy, frame_done, start_err. Response begins T_WAIT cycles after accepted release; no backpressure.
module dht11_sensor_emulator
    import dht11_sensor_emulator_pkg::*;
#(
    parameter int T_START_MIN = T_START_MIN_DEF,
    parameter int T_WAIT      = T_WAIT_DEF,
    parameter int T_RESP_LOW  = T_RESP_LOW_DEF,
    parameter int T_RESP_HIGH = T_RESP_HIGH_DEF,
    parameter int T_BIT_LOW   = T_BIT_LOW_DEF,
    parameter int T_ZERO_HIGH = T_ZERO_HIGH_DEF,
    parameter int T_ONE_HIGH  = T_ONE_HIGH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    input  logic       dht_in,
    output logic       dht_oe,
    output logic       busy,
    output logic       frame_done,
    output logic       start_err
);

    localparam int CNT_W = $clog2(T_START_MIN + 1);

    dht_state_t             state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [BIT_IDX_W-1:0]   idx, idx_nxt;
    logic [FRAME_W-1:0]     shift, shift_nxt;
    logic [31:0]            shadow, live_vals;
    logic                   busy_nxt, oe_nxt, done_nxt, err_nxt;
    logic                   line_rise, line_fall, host_rise, host_fall;

    dht11_line_sync u_line_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (dht_in),
        .rise (line_rise),
        .fall (line_fall)
    );

    // Our own drive shows up on dht_in; only edges seen while released belong to the host.
    assign host_rise = line_rise & ~dht_oe;
    assign host_fall = line_fall & ~dht_oe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) shadow <= '0;
        else if (load) shadow <= {hum_int, hum_dec, temp_int, temp_dec};
    end

    // A load coinciding with start accept must reach the snapshot, so bypass the shadow.
    assign live_vals = load ? {hum_int, hum_dec, temp_int, temp_dec} : shadow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            busy       <= 1'b0;
            dht_oe     <= 1'b0;
            frame_done <= 1'b0;
            start_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shift      <= shift_nxt;
            busy       <= busy_nxt;
            dht_oe     <= oe_nxt;
            frame_done <= done_nxt;
            start_err  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shift_nxt = shift;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (host_fall) begin
                    state_nxt = ST_HOST_LOW;
                    cnt_nxt   = '0;
                end
            end
            ST_HOST_LOW: begin
                // The falling-edge cycle itself is not counted, so a host low of exactly
                // T_START_MIN cycles leaves T_START_MIN-1 here when the rising edge arrives.
                if (host_rise) begin
                    if (cnt >= CNT_W'(T_START_MIN - 1)) begin
                        shift_nxt = build_frame(live_vals);
                        busy_nxt  = 1'b1;
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_W'(T_WAIT - 1);
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else if (cnt < CNT_W'(T_START_MIN)) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_RESP_LOW;
                    cnt_nxt   = CNT_W'(T_RESP_LOW - 1);
                end else cnt_nxt = cnt - 1'b1;
            end
            ST_RESP_LOW: begin
                if (cnt == '0) begin
                    state_nxt = ST_RESP_HIGH;
                    cnt_nxt   = CNT_W'(T_RESP_HIGH - 1);
                end else cnt_nxt = cnt - 1'b1;
            end
            ST_RESP_HIGH: begin
                if (cnt == '0) begin
                    state_nxt = ST_BIT_LOW;
                    cnt_nxt   = CNT_W'(T_BIT_LOW - 1);
                    idx_nxt   = BIT_IDX_W'(FRAME_W - 1);
                end else cnt_nxt = cnt - 1'b1;
            end
            ST_BIT_LOW: begin
                if (cnt == '0) begin
                    state_nxt = ST_BIT_HIGH;
                    cnt_nxt   = shift[FRAME_W-1] ? CNT_W'(T_ONE_HIGH - 1) : CNT_W'(T_ZERO_HIGH - 1);
                end else cnt_nxt = cnt - 1'b1;
            end
            ST_BIT_HIGH: begin
                if (cnt == '0) begin
                    cnt_nxt = CNT_W'(T_BIT_LOW - 1);
                    if (idx != '0) begin
                        idx_nxt   = idx - 1'b1;
                        shift_nxt = shift << 1;
                        state_nxt = ST_BIT_LOW;
                    end else begin
                        state_nxt = ST_END_LOW;
                    end
                end else cnt_nxt = cnt - 1'b1;
            end
            ST_END_LOW: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end else cnt_nxt = cnt - 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Registered from the next state so the pull changes exactly on phase boundaries.
        oe_nxt = (state_nxt == ST_RESP_LOW) || (state_nxt == ST_BIT_LOW) || (state_nxt == ST_END_LOW);
    end

endmodule

// File: tb/tb_dht11_sensor_emulator.sv
`timescale 1ns/1ps
module tb_dht11_sensor_emulator;

    // Start threshold shortened to keep the run short; every other phase uses the real table.
    localparam int T_START = 1000;
    localparam int T_WAIT  = 30;
    localparam int T_RLOW  = 80;
    localparam int T_RHIGH = 80;
    localparam int T_BLOW  = 50;
    localparam int T_ZERO  = 26;
    localparam int T_ONE   = 70;
    // Host release -> first response low: 2 synchroniser cycles, 1 accept cycle, then the wait phase.
    localparam int RESP_LAT = 2 + 1 + T_WAIT;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] hum_int = '0, hum_dec = '0, temp_int = '0, temp_dec = '0;
    logic       host_pull = 1'b0;
    logic       glitch = 1'b0;
    logic       dht_in;
    logic       dht_oe, busy, frame_done, start_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the sensor's stored values.
    logic [7:0] m_hi = '0, m_hd = '0, m_ti = '0, m_td = '0;

    // Wired-AND open-drain line with pull-up.
    assign dht_in = ~(host_pull | glitch | dht_oe);

    always #500 clk = ~clk;

    dht11_sensor_emulator #(.T_START_MIN(T_START)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .hum_int    (hum_int),
        .hum_dec    (hum_dec),
        .temp_int   (temp_int),
        .temp_dec   (temp_dec),
        .dht_in     (dht_in),
        .dht_oe     (dht_oe),
        .busy       (busy),
        .frame_done (frame_done),
        .start_err  (start_err)
    );

    function automatic logic [39:0] expect_frame(input logic [7:0] a, b, c, d);
        int s;
        s = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
        return {a, b, c, d, 8'(s)};
    endfunction

    task automatic load_values(input logic [7:0] a, b, c, d);
        hum_int = a; hum_dec = b; temp_int = c; temp_dec = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        m_hi = a; m_hd = b; m_ti = c; m_td = d;
    endtask

    task automatic host_low(input int n);
        host_pull = 1'b1;
        repeat (n) @(negedge clk);
        host_pull = 1'b0;
    endtask

    task automatic measure_run(input logic level, output int len);
        len = 0;
        while (dht_oe === level && len < 1000) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_oe(input bit poke, output int lat);
        lat = 0;
        while (dht_oe !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 5)  host_pull = 1'b1;
            if (poke && lat == 10) host_pull = 1'b0;
        end
    endtask

    // Full start + frame; decodes the 40 bits from the pull widths.
    task automatic run_frame(input string name, input logic [39:0] exp, input bit mid_load,
                             input bit poke, output logic [39:0] got);
        int lat, len, want;
        got = '0;
        host_low(T_START);
        wait_oe(poke, lat);
        n_checks++;
        if (lat !== RESP_LAT) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, RESP_LAT);
            if (lat >= 200) return;
        end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy during response: got %b want 1", name, busy); end
        measure_run(1'b1, len);
        n_checks++;
        if (len !== T_RLOW) begin n_fail++; $display("FAIL %s resp_low: got %0d want %0d", name, len, T_RLOW); end
        measure_run(1'b0, len);
        n_checks++;
        if (len !== T_RHIGH) begin n_fail++; $display("FAIL %s resp_high: got %0d want %0d", name, len, T_RHIGH); end
        for (int i = 0; i < 40; i++) begin
            if (mid_load && i == 10) begin
                load_values(8'hFF, 8'hFF, 8'hFF, 8'h03);
                measure_run(1'b1, len);
                len++;
            end else begin
                measure_run(1'b1, len);
            end
            n_checks++;
            if (len !== T_BLOW) begin n_fail++; $display("FAIL %s bit%0d low: got %0d want %0d", name, i, len, T_BLOW); end
            measure_run(1'b0, len);
            want = exp[39-i] ? T_ONE : T_ZERO;
            got[39-i] = (len > (T_ZERO + T_ONE) / 2);
            n_checks++;
            if (len !== want) begin n_fail++; $display("FAIL %s bit%0d high: got %0d want %0d", name, i, len, want); end
        end
        measure_run(1'b1, len);
        n_checks++;
        if (len !== T_BLOW) begin n_fail++; $display("FAIL %s end_low: got %0d want %0d", name, len, T_BLOW); end
        n_checks++;
        if ({frame_done, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s end flags: frame_done,busy got %b%b want 10", name, frame_done, busy);
        end
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL %s frame_done width: got %b want 0", name, frame_done); end
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL %s frame: got %h want %h", name, got, exp); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({dht_oe, busy, frame_done, start_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset outputs: got %b want 0000", {dht_oe, busy, frame_done, start_err});
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({dht_oe, busy} !== 2'b00) begin n_fail++; $display("FAIL reset idle: got %b want 00", {dht_oe, busy}); end
    endtask

    task automatic test_glitch;
        bit seen = 0;
        glitch = 1'b1;            // exactly one sampled low cycle
        @(negedge clk);
        glitch = 1'b0;
        #100 glitch = 1'b1;       // sub-cycle pulse between clock edges
        #200 glitch = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (dht_oe || busy) seen = 1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL glitch: response activity got %b want 0", seen); end
    endtask

    task automatic test_short_start;
        int errs = 0;
        bit seen = 0;
        host_low(T_START - 1);
        repeat (150) begin
            @(negedge clk);
            if (start_err) errs++;
            if (dht_oe || busy) seen = 1;
        end
        n_checks++;
        if (errs !== 1) begin n_fail++; $display("FAIL short_start start_err pulses: got %0d want 1", errs); end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL short_start activity: got %b want 0", seen); end
    endtask

    task automatic test_basic_frame;
        logic [39:0] got;
        logic [7:0]  b0;
        load_values(8'h37, 8'h00, 8'h19, 8'h05);
        run_frame("basic", expect_frame(m_hi, m_hd, m_ti, m_td), 0, 0, got);
        b0 = got[39:32];
        n_checks++;
        if (b0 !== 8'b00110111) begin n_fail++; $display("FAIL basic hum_int bits: got %b want 00110111", b0); end
        n_checks++;
        if (got[7:0] !== 8'h55) begin n_fail++; $display("FAIL basic checksum: got %h want 55", got[7:0]); end
    endtask

    task automatic abort_frame(input string name, input bit in_bits);
        int lat, len;
        host_low(T_START);
        wait_oe(0, lat);
        if (in_bits) begin
            measure_run(1'b1, len);
            measure_run(1'b0, len);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (dht_oe !== 1'b1) begin n_fail++; $display("FAIL %s pre-reset pull: got %b want 1", name, dht_oe); end
        #100 rst = 1'b0;
        #1;
        n_checks++;
        if ({dht_oe, busy} !== 2'b00) begin n_fail++; $display("FAIL %s async reset: got %b want 00", name, {dht_oe, busy}); end
        @(negedge clk);
        rst = 1'b1;
        m_hi = '0; m_hd = '0; m_ti = '0; m_td = '0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        logic [39:0] got;
        abort_frame("rst_resp_low", 0);
        abort_frame("rst_bit_low", 1);
        run_frame("after_reset", expect_frame(m_hi, m_hd, m_ti, m_td), 0, 0, got);
    endtask

    task automatic test_back_to_back;
        logic [39:0] got;
        load_values(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        run_frame("old_values", expect_frame(m_hi, m_hd, m_ti, m_td), 1, 0, got);
        run_frame("new_values", expect_frame(m_hi, m_hd, m_ti, m_td), 0, 1, got);
        n_checks++;
        if (got[7:0] !== 8'h00) begin n_fail++; $display("FAIL wrap checksum: got %h want 00", got[7:0]); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_short_start();
        test_basic_frame();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
